// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: forward-select codes, the
// "source unused" Tuse code, default mult/div latencies and the default-width
// stage record.
package hazard_pkg;

  localparam int unsigned RA_W_DEF     = 5;
  localparam int unsigned T_W_DEF      = 2;

  // Forward-select codes: 0 = register file / E register value, k = stage k
  localparam int unsigned SEL_GRF      = 0;
  localparam int unsigned SEL_E        = 1;
  localparam int unsigned SEL_M        = 2;
  localparam int unsigned SEL_W        = 3;

  // Tuse code for a source the instruction does not read
  localparam int unsigned TUSE_NONE    = 3;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  // Shadow-pipeline record at the default widths
  typedef struct packed {
    logic                valid;
    logic [RA_W_DEF-1:0] wreg;
    logic [T_W_DEF-1:0]  tnew;
  } stage_rec_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage decoder <-> hazard scoreboard bundle.
// master (decoder): drives the d_* instruction description, receives
//                   stall, the four forward selects and md_busy.
// slave  (scoreboard): the reverse.
interface hazard_scoreboard_if #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned T_W   = 2,
  parameter int unsigned SEL_W = 3
);

  logic            d_valid;
  logic [RA_W-1:0] d_rs;
  logic [RA_W-1:0] d_rt;
  logic [T_W-1:0]  d_tuse_rs;
  logic [T_W-1:0]  d_tuse_rt;
  logic [RA_W-1:0] d_wreg;
  logic [T_W-1:0]  d_tnew;
  logic            d_md_start;
  logic            d_md_div;
  logic            d_uses_hilo;

  logic             stall;
  logic [SEL_W-1:0] fwd_rs_d;
  logic [SEL_W-1:0] fwd_rt_d;
  logic [SEL_W-1:0] fwd_rs_e;
  logic [SEL_W-1:0] fwd_rt_e;
  logic             md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wreg, d_tnew,
           d_md_start, d_md_div, d_uses_hilo,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wreg, d_tnew,
           d_md_start, d_md_div, d_uses_hilo,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
  );

endinterface

// File: rtl/hazard_md_tracker.sv
// HI/LO unit occupancy counter.
// Ports: clk, reset (sync, active-high), start (accepted mult/div issue),
//        is_div (select divide latency), busy (counter nonzero).
module hazard_md_tracker #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [CNT_W-1:0] cnt;

  // Load on an accepted issue, otherwise count down to idle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard beside the decode stage. Keeps its own shadow pipeline of
// destination/Tnew records for stages 1..N_STAGES (E, M, W, ...) and derives
// the D stall, D/E forward selects and HI/LO busy from that state plus the
// current D instruction, all within the same cycle.
// Ports: clk, reset (sync, active-high), bus (slave side of
//        hazard_scoreboard_if: d_* inputs, stall/fwd_*/md_busy outputs).
module hazard_scoreboard #(
  parameter int unsigned RA_W     = hazard_pkg::RA_W_DEF,
  parameter int unsigned T_W      = hazard_pkg::T_W_DEF,
  parameter int unsigned N_STAGES = 3,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned MULT_LAT = hazard_pkg::MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = hazard_pkg::DIV_LAT_DEF,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scoreboard_if.slave bus
);

  import hazard_pkg::*;

  localparam int unsigned IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] wreg;
    logic [T_W-1:0]  tnew;
  } rec_t;

  // stg[k-1] is shadow stage k; e_rs/e_rt are the sources of stage 1
  rec_t            stg [N_STAGES];
  logic [RA_W-1:0] e_rs;
  logic [RA_W-1:0] e_rt;

  logic haz_rs;
  logic haz_rt;
  logic stall_now;
  logic md_busy;
  logic md_start;

  // Select of the lowest matching stage >= lo, nonzero only if its result is ready
  function automatic logic [SEL_W-1:0] fwd_sel(input logic [RA_W-1:0] src,
                                               input int unsigned    lo,
                                               input rec_t           st [N_STAGES]);
    logic [SEL_W-1:0] sel;
    sel = SEL_W'(SEL_GRF);
    // Walk from the oldest stage down so the youngest match wins
    for (int k = N_STAGES; k >= 1; k--) begin
      if (k >= int'(lo) && src != '0 && st[IDX_W'(k - 1)].valid &&
          st[IDX_W'(k - 1)].wreg == src) begin
        sel = (st[IDX_W'(k - 1)].tnew == '0) ? SEL_W'(k) : SEL_W'(SEL_GRF);
      end
    end
    return sel;
  endfunction

  // Data hazard against the lowest matching stage
  function automatic logic raw_hazard(input logic [RA_W-1:0] src,
                                      input logic [T_W-1:0]  tuse,
                                      input rec_t            st [N_STAGES]);
    logic hit;
    hit = 1'b0;
    for (int k = N_STAGES; k >= 1; k--) begin
      if (src != '0 && st[IDX_W'(k - 1)].valid && st[IDX_W'(k - 1)].wreg == src) begin
        hit = (tuse < st[IDX_W'(k - 1)].tnew);
      end
    end
    return hit;
  endfunction

  // Stall, forward selects and busy, combinational from state + D inputs
  always_comb begin
    haz_rs    = raw_hazard(bus.d_rs, bus.d_tuse_rs, stg);
    haz_rt    = raw_hazard(bus.d_rt, bus.d_tuse_rt, stg);
    stall_now = haz_rs | haz_rt | (bus.d_valid & bus.d_uses_hilo & md_busy);
    md_start  = bus.d_valid & bus.d_md_start & ~stall_now;

    bus.stall    = stall_now;
    bus.md_busy  = md_busy;
    bus.fwd_rs_d = fwd_sel(bus.d_rs, 1, stg);
    bus.fwd_rt_d = fwd_sel(bus.d_rt, 1, stg);
    // E never forwards from itself, hence stages 2 and up
    bus.fwd_rs_e = fwd_sel(e_rs, 2, stg);
    bus.fwd_rt_e = fwd_sel(e_rt, 2, stg);
  end

  // Shadow pipeline: stage 1 takes D or a bubble, later stages age Tnew
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_STAGES; k++) begin
        stg[k] <= '0;
      end
      e_rs <= '0;
      e_rt <= '0;
    end else begin
      if (stall_now) begin
        stg[0] <= '0;
        e_rs   <= '0;
        e_rt   <= '0;
      end else begin
        stg[0].valid <= bus.d_valid;
        stg[0].wreg  <= bus.d_wreg;
        stg[0].tnew  <= bus.d_tnew;
        e_rs         <= bus.d_rs;
        e_rt         <= bus.d_rt;
      end
      for (int k = 1; k < N_STAGES; k++) begin
        stg[k].valid <= stg[k-1].valid;
        stg[k].wreg  <= stg[k-1].wreg;
        stg[k].tnew  <= (stg[k-1].tnew == '0) ? '0 : stg[k-1].tnew - T_W'(1);
      end
    end
  end

  hazard_md_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (bus.d_md_div),
    .busy   (md_busy)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, hand
// sequences for mult/div occupancy and reset, then random stimulus against a
// cycle-stamped instruction-history model.
module tb_hazard_scoreboard;

  localparam int unsigned RA_W     = 5;
  localparam int unsigned T_W      = 2;
  localparam int unsigned N_STAGES = 3;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;
  localparam int unsigned CNT_W    = 4;
  localparam int          HIST     = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.RA_W(RA_W), .T_W(T_W), .SEL_W(SEL_W)) bus ();

  hazard_scoreboard #(
    .RA_W(RA_W), .T_W(T_W), .N_STAGES(N_STAGES), .SEL_W(SEL_W),
    .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       val;
    logic [4:0] rs, rt;
    logic [1:0] tur, tut;
    logic [4:0] wreg;
    logic [1:0] tnew;
    logic       mds, mdd, hilo;
  } drv_t;

  typedef struct {
    logic       stall;
    logic [2:0] frsd, frtd, frse, frte;
    logic       busy;
  } exp_t;

  typedef struct {
    drv_t d;
    exp_t e;
  } vec_t;

  // Instruction occupying stage 1 (E) during a given cycle
  typedef struct {
    bit valid;
    int wreg;
    int tnew;
    int rs;
    int rt;
  } ent_t;

  ent_t hist [HIST];
  int   cyc      = 8;
  int   busy_end = 0;
  int   checks   = 0;
  int   errors   = 0;
  vec_t tbl [$];

  function automatic drv_t mk_d(bit rst, bit val, int rs, int rt, int tur, int tut,
                                int wreg, int tnew, bit mds, bit mdd, bit hilo);
    drv_t d;
    d.rst = rst; d.val = val; d.rs = 5'(rs); d.rt = 5'(rt);
    d.tur = 2'(tur); d.tut = 2'(tut); d.wreg = 5'(wreg); d.tnew = 2'(tnew);
    d.mds = mds; d.mdd = mdd; d.hilo = hilo;
    return d;
  endfunction

  function automatic exp_t mk_e(bit st, int frsd, int frtd, int frse, int frte, bit busy);
    exp_t e;
    e.stall = st; e.frsd = 3'(frsd); e.frtd = 3'(frtd);
    e.frse = 3'(frse); e.frte = 3'(frte); e.busy = busy;
    return e;
  endfunction

  function automatic drv_t nop();
    return mk_d(0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
  endfunction

  function automatic drv_t mflo(bit rst);
    return mk_d(rst, 1, 0, 0, 3, 3, 9, 1, 0, 0, 1);
  endfunction

  function automatic exp_t zero_e();
    return mk_e(0, 0, 0, 0, 0, 0);
  endfunction

  // Lowest stage >= lo holding a valid writer of src in cycle t
  function automatic void lookup(input int src, input int lo, input int tuse, input int t,
                                 output bit hz, output int sel);
    ent_t en;
    int   tn;
    hz = 0; sel = 0;
    if (src == 0) return;
    for (int k = lo; k <= int'(N_STAGES); k++) begin
      en = hist[t - k + 1];
      tn = en.tnew - (k - 1);
      if (tn < 0) tn = 0;
      if (en.valid && en.wreg == src) begin
        hz  = (tuse < tn);
        sel = (tn == 0) ? k : 0;
        return;
      end
    end
  endfunction

  function automatic exp_t model_eval(drv_t d);
    exp_t e;
    bit   hz_rs, hz_rt, hz_x;
    int   s_rs, s_rt, s_ers, s_ert;
    lookup(int'(d.rs), 1, int'(d.tur), cyc, hz_rs, s_rs);
    lookup(int'(d.rt), 1, int'(d.tut), cyc, hz_rt, s_rt);
    lookup(hist[cyc].rs, 2, 3, cyc, hz_x, s_ers);
    lookup(hist[cyc].rt, 2, 3, cyc, hz_x, s_ert);
    e.busy  = (cyc <= busy_end);
    e.stall = hz_rs || hz_rt || (d.val && d.hilo && e.busy);
    e.frsd  = 3'(s_rs);
    e.frtd  = 3'(s_rt);
    e.frse  = 3'(s_ers);
    e.frte  = 3'(s_ert);
    return e;
  endfunction

  task automatic model_update(input drv_t d, input bit st);
    ent_t empty;
    empty = '{0, 0, 0, 0, 0};
    if (d.rst) begin
      for (int j = 0; j <= int'(N_STAGES); j++) hist[cyc + 1 - j] = empty;
      busy_end = cyc;
    end else begin
      if (st) hist[cyc + 1] = empty;
      else    hist[cyc + 1] = '{d.val, int'(d.wreg), int'(d.tnew), int'(d.rs), int'(d.rt)};
      if (d.val && d.mds && !st)
        busy_end = cyc + int'(d.mdd ? DIV_LAT : MULT_LAT);
    end
    cyc++;
  endtask

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    cmp({tag, "_stall"},    8'(bus.stall),    8'(e.stall));
    cmp({tag, "_fwd_rs_d"}, 8'(bus.fwd_rs_d), 8'(e.frsd));
    cmp({tag, "_fwd_rt_d"}, 8'(bus.fwd_rt_d), 8'(e.frtd));
    cmp({tag, "_fwd_rs_e"}, 8'(bus.fwd_rs_e), 8'(e.frse));
    cmp({tag, "_fwd_rt_e"}, 8'(bus.fwd_rt_e), 8'(e.frte));
    cmp({tag, "_md_busy"},  8'(bus.md_busy),  8'(e.busy));
  endtask

  // One cycle: drive at edge+1, sample at edge+3, advance to next edge+1
  task automatic run(input string tag, input drv_t d, input exp_t e,
                     input bit use_exp, input bit chk_en);
    exp_t m;
    reset           = d.rst;
    bus.d_valid     = d.val;
    bus.d_rs        = d.rs;
    bus.d_rt        = d.rt;
    bus.d_tuse_rs   = d.tur;
    bus.d_tuse_rt   = d.tut;
    bus.d_wreg      = d.wreg;
    bus.d_tnew      = d.tnew;
    bus.d_md_start  = d.mds;
    bus.d_md_div    = d.mdd;
    bus.d_uses_hilo = d.hilo;
    #2;
    m = model_eval(d);
    if (chk_en) begin
      cmp_all({tag, "_model"}, m);
      if (use_exp) cmp_all(tag, e);
    end
    model_update(d, m.stall);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input drv_t d, input exp_t e);
    tbl.push_back('{d, e});
  endtask

  task automatic busy_seq(input string tag, input bit is_div, input int lat);
    run({tag, "_issue"}, mk_d(0, 1, 0, 0, 3, 3, 0, 0, 1, is_div, 1), zero_e(), 1, 1);
    for (int i = 0; i < lat; i++)
      run($sformatf("%s_busy%0d", tag, i), mflo(0), mk_e(1, 0, 0, 0, 0, 1), 1, 1);
    run({tag, "_done"}, mflo(0), zero_e(), 1, 1);
    for (int i = 0; i < 3; i++) run({tag, "_nop"}, nop(), zero_e(), 1, 1);
  endtask

  function automatic drv_t rand_drv();
    drv_t d;
    d.rst  = ($urandom_range(0, 99) == 0);
    d.val  = ($urandom_range(0, 9) < 8);
    d.rs   = 5'($urandom_range(0, 3));
    d.rt   = 5'($urandom_range(0, 3));
    d.tur  = 2'($urandom_range(0, 3));
    d.tut  = 2'($urandom_range(0, 3));
    d.wreg = 5'($urandom_range(0, 3));
    d.tnew = 2'($urandom_range(0, 3));
    d.mds  = ($urandom_range(0, 9) == 0);
    d.mdd  = 1'($urandom_range(0, 1));
    d.hilo = d.mds | ($urandom_range(0, 9) == 0);
    return d;
  endfunction

  initial begin
    drv_t d;
    reset = 1'b1;
    @(posedge clk);
    #1;
    run("rst0", mk_d(1, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0), zero_e(), 0, 0);
    run("rst1", mk_d(1, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0), zero_e(), 0, 0);

    //   rst val rs rt tur tut wreg tnew mds mdd hilo     st rsd rtd rse rte busy
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));
    // load-use: lw $1 then add rs=$1 tuse=1
    add(mk_d(0, 1, 0, 0, 3, 3, 1, 2, 0, 0, 0),      mk_e(0, 0, 0, 0, 0, 0));
    add(mk_d(0, 1, 1, 5, 1, 1, 4, 1, 0, 0, 0),      mk_e(1, 0, 0, 0, 0, 0));
    add(mk_d(0, 1, 1, 5, 1, 1, 4, 1, 0, 0, 0),      mk_e(0, 0, 0, 0, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 3, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));
    // branch after lw: beq rs=$1 tuse=0
    add(mk_d(0, 1, 0, 0, 3, 3, 1, 2, 0, 0, 0),      mk_e(0, 0, 0, 0, 0, 0));
    add(mk_d(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0),      mk_e(1, 0, 0, 0, 0, 0));
    add(mk_d(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0),      mk_e(1, 0, 0, 0, 0, 0));
    add(mk_d(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0),      mk_e(0, 3, 0, 0, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));
    // ALU forward: addu $3 then or rt=$3
    add(mk_d(0, 1, 0, 0, 3, 3, 3, 1, 0, 0, 0),      mk_e(0, 0, 0, 0, 0, 0));
    add(mk_d(0, 1, 0, 3, 3, 1, 6, 1, 0, 0, 0),      mk_e(0, 0, 0, 0, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 2, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));
    // same through $0: never matches
    add(mk_d(0, 1, 0, 0, 3, 3, 0, 1, 0, 0, 0),      mk_e(0, 0, 0, 0, 0, 0));
    add(mk_d(0, 1, 0, 0, 0, 1, 6, 1, 0, 0, 0),      mk_e(0, 0, 0, 0, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));
    // priority: $31 written in stages 1 and 2, youngest wins
    add(mk_d(0, 1, 0, 0, 3, 3, 31, 0, 0, 0, 0),     mk_e(0, 0, 0, 0, 0, 0));
    add(mk_d(0, 1, 0, 0, 3, 3, 31, 0, 0, 0, 0),     mk_e(0, 0, 0, 0, 0, 0));
    add(mk_d(0, 1, 31, 0, 0, 3, 0, 0, 0, 0, 0),     mk_e(0, 1, 0, 0, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 2, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));
    // independent rs/rt: rs ready in M, rt stalls behind E
    add(mk_d(0, 1, 0, 0, 3, 3, 7, 0, 0, 0, 0),      mk_e(0, 0, 0, 0, 0, 0));
    add(mk_d(0, 1, 0, 0, 3, 3, 8, 1, 0, 0, 0),      mk_e(0, 0, 0, 0, 0, 0));
    add(mk_d(0, 1, 7, 8, 1, 0, 0, 0, 0, 0, 0),      mk_e(1, 2, 0, 0, 0, 0));
    add(mk_d(0, 1, 7, 8, 1, 0, 0, 0, 0, 0, 0),      mk_e(0, 3, 2, 0, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 3, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));
    add(nop(),                                       mk_e(0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) run($sformatf("v%0d", i), tbl[i].d, tbl[i].e, 1, 1);

    busy_seq("mult", 0, int'(MULT_LAT));
    busy_seq("div", 1, int'(DIV_LAT));

    // reset on the third busy cycle of a divide
    run("rdiv_issue", mk_d(0, 1, 0, 0, 3, 3, 0, 0, 1, 1, 1), zero_e(), 1, 1);
    run("rdiv_b1", mflo(0), mk_e(1, 0, 0, 0, 0, 1), 1, 1);
    run("rdiv_b2", mflo(0), mk_e(1, 0, 0, 0, 0, 1), 1, 1);
    run("rdiv_b3", mflo(1), mk_e(1, 0, 0, 0, 0, 1), 1, 1);
    run("rdiv_after", mflo(0), zero_e(), 1, 1);
    run("rdiv_nop", nop(), zero_e(), 1, 1);

    for (int i = 0; i < 1500; i++) begin
      d = rand_drv();
      run("rnd", d, zero_e(), 0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor of the stage-compare hazard unit.
- Owns its own shadow pipeline of destination and Tnew records for stages E..W (N_STAGES deep) instead of taking per-stage Tnew/WriteReg inputs.
- Tracks multi-cycle multiply/divide occupancy and produces stall, bubble and forwarding selects for D and E.
- Sits beside the decode stage. It is fed once per cycle by the D-stage decoder.

Parameters:
- RA_W, 5, register address width
- T_W, 2, Tuse/Tnew width
- N_STAGES, 3, tracked stages after D (1=E, 2=M, 3=W); legal range 2..7
- SEL_W, 3, forward-select width; must satisfy 2^SEL_W > N_STAGES
- MULT_LAT, 5, multiply busy cycles
- DIV_LAT, 10, divide busy cycles
- CNT_W, 4, busy counter width; must hold max(MULT_LAT, DIV_LAT)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- d_valid  in  1  D holds a real instruction
- d_rs  in  RA_W  D source register 1
- d_rt  in  RA_W  D source register 2
- d_tuse_rs  in  T_W  cycles until D needs rs (3 = unused)
- d_tuse_rt  in  T_W  cycles until D needs rt (3 = unused)
- d_wreg  in  RA_W  D destination (0 = none)
- d_tnew  in  T_W  Tnew of the D instruction measured at E
- d_md_start  in  1  D is mult/multu/div/divu
- d_md_div  in  1  1 = divide latency, 0 = multiply latency
- d_uses_hilo  in  1  D reads/writes HI/LO; must be 1 whenever d_md_start is 1
- stall  out  1  freeze PC and F/D; insert bubble into E
- fwd_rs_d  out  SEL_W  D rs source: 0 = GRF, k = stage k
- fwd_rt_d  out  SEL_W  D rt source: 0 = GRF, k = stage k
- fwd_rs_e  out  SEL_W  E rs source: 0 = E register value, k = stage k (k ≥ 2)
- fwd_rt_e  out  SEL_W  E rt source: 0 = E register value, k = stage k (k ≥ 2)
- md_busy  out  1  HI/LO unit occupied

Behaviour:
- Shadow stage k holds: valid, wreg, tnew; stage 1 additionally holds rs and rt.
- Every edge, stages 2..N_STAGES load from stage k-1 with tnew_next = (tnew==0) ? 0 : tnew-1.
- Stage 1 loads on each edge:
  - stall=0: the D record, with valid = d_valid.
  - stall=1: a bubble (valid=0, wreg=0, tnew=0).
- Match(src, k) := src != 0 && stage k valid && stage k wreg == src.
- Stall: for each D source, take the lowest matching k. stall = 1 if tuse < tnew[k] for that k, OR if (d_valid && d_uses_hilo && md_busy).
- D forward select: the lowest matching k with tnew[k] == 0. If the lowest match has tnew > 0, the select is 0 and resolution happens later or through the stall.
- E forward select: same rule using stage-1 rs/rt against stages 2..N_STAGES. Stage 1 is never selected for E.
- All selects are 0 when no match exists. Register 0 never matches.
- Busy counter:
  - On an edge with d_valid && d_md_start && !stall, load MULT_LAT or DIV_LAT.
  - Otherwise, decrement when nonzero.
  - md_busy = (cnt != 0), registered-state derived.
- A mult issued while busy is stalled by the HI/LO rule and never reloads the counter early.
- Outputs are combinational from the registered state plus D inputs. Zero latency within the cycle.
- Reset, including mid-operation: all valid bits, wreg, tnew and cnt cleared at the edge. The following cycle shows stall=0 (no matches, md_busy=0) and all selects 0.
- Simultaneous hazards on rs and rt are OR-ed. Selects for rs and rt are independent.

Decomposition:
- Shared package hazard_pkg holds:
  - forward-select constants: SEL_GRF=0, SEL_E=1, SEL_M=2, SEL_W=3
  - TUSE_NONE=3
  - the stage record struct (valid, wreg, tnew)
  - MULT_LAT and DIV_LAT defaults
- Sub-module hazard_md_tracker: the busy counter with load/decrement and the md_busy output.

Test Plan:
- Load-use stall: lw $1 (d_tnew=2) issued, then add with rs=$1, tuse=1.
  - Required: stall=1 for exactly 1 cycle, fwd_rs_d=0.
  - When the add is in E: fwd_rs_e=3.
- Branch after lw: beq with rs=$1, tuse=0, following lw $1.
  - Required: stall for 2 cycles, then fwd_rs_d=3 with stall=0.
- ALU result forward: addu $3 (tnew=1) then or with rt=$3, tuse=1.
  - Required: no stall, fwd_rt_e=2 in the next cycle.
  - Producer to register $0 with the same sequence: all selects 0, no stall.
- Priority: jal-style writes to $31 in both stage 1 and stage 2, each with tnew=0; D reads $31.
  - Required: fwd_rs_d=1.
- mult then mflo (d_uses_hilo=1) on back-to-back cycles.
  - Required: md_busy high for 5 cycles, stall high for those 5 cycles.
  - Same test with div: 10 cycles.
- Assert reset on the 3rd busy cycle of a div.
  - Required: next cycle md_busy=0, stall=0, all selects 0, and the pending mflo proceeds.
